// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default widths, op codes, FSM states.
// The signed mode is controlled by the MULDIV_SIGNED_EN macro, which is used in muldiv_unit.
package muldiv_pkg;

   localparam int unsigned DEFAULT_WIDTH      = 8;
   localparam int unsigned DEFAULT_REG_ADDR_W = 3;

   localparam logic [1:0] OP_MULLO = 2'b00;
   localparam logic [1:0] OP_MULHI = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_REM   = 2'b11;
   localparam int unsigned OP_SIGNED_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the datapath: shift-add multiply or restoring divide.
// hi holds the upper product half / partial remainder, lo the multiplier / quotient bits.
module muldiv_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] sub;
   logic             fits;

   always_comb begin
      sum     = '0;
      shifted = '0;
      sub     = '0;
      fits    = 1'b0;
      hi_o    = hi_i;
      lo_o    = lo_i;
      if (is_div_i) begin
         shifted = {hi_i, lo_i[WIDTH-1]};
         fits    = (shifted >= {1'b0, b_i});
         // Remainder stays below the divisor, so the low WIDTH bits carry the full difference.
         sub     = shifted[WIDTH-1:0] - b_i;
         hi_o    = fits ? sub : shifted[WIDTH-1:0];
         lo_o    = {lo_i[WIDTH-2:0], fits};
      end else begin
         sum  = lo_i[0] ? ({1'b0, hi_i} + {1'b0, b_i}) : {1'b0, hi_i};
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-cycle multiply/divide unit feeding the register-bank write port.
// Define MULDIV_SIGNED_EN to honour op[2] as a two's-complement select.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [WIDTH-1:0]      operandA,
   input  logic [WIDTH-1:0]      operandB,
   input  logic [REG_ADDR_W-1:0] destReg,
   output logic                  busy,
   output logic                  done,
   output logic                  writeEnable,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] resultReg,
   output logic                  divByZero
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic [REG_ADDR_W-1:0] result_reg_q, result_reg_d;
   logic                  div_zero_q, div_zero_d;

   logic                  accept;
   logic [WIDTH-1:0]      mag_a, mag_b, step_hi, step_lo;
   logic [2*WIDTH-1:0]    prod, prod_f;
   logic [WIDTH-1:0]      quot, quot_f, rem, rem_f, final_res;
   logic                  b_zero;

   assign accept = (state_q == ST_IDLE) && start;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (op_q[1]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   assign prod   = {step_hi, step_lo};
   assign quot   = step_lo;
   assign rem    = step_hi;
   assign b_zero = (b_q == '0);

`ifdef MULDIV_SIGNED_EN
   logic neg_a, neg_b, neg_a_q, neg_r_q;

   assign neg_a = op[OP_SIGNED_BIT] & operandA[WIDTH-1];
   assign neg_b = op[OP_SIGNED_BIT] & operandB[WIDTH-1];
   assign mag_a = neg_a ? -operandA : operandA;
   assign mag_b = neg_b ? -operandB : operandB;

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_a_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (accept) begin
         neg_a_q <= neg_a;
         neg_r_q <= neg_a ^ neg_b;
      end
   end

   // Divide by zero keeps the all-ones quotient regardless of operand signs.
   assign prod_f = neg_r_q ? -prod : prod;
   assign quot_f = b_zero ? '1 : (neg_r_q ? -quot : quot);
   assign rem_f  = neg_a_q ? -rem : rem;
`else
   logic unused_signed;

   assign unused_signed = op[OP_SIGNED_BIT];
   assign mag_a         = operandA;
   assign mag_b         = operandB;
   assign prod_f        = prod;
   assign quot_f        = quot;
   assign rem_f         = rem;
`endif

   always_comb begin
      final_res = '0;
      unique case (op_q)
         OP_MULLO: final_res = prod_f[WIDTH-1:0];
         OP_MULHI: final_res = prod_f[2*WIDTH-1:WIDTH];
         OP_DIV:   final_res = quot_f;
         OP_REM:   final_res = rem_f;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      dest_d       = dest_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      b_d          = b_q;
      result_d     = result_q;
      result_reg_d = result_reg_q;
      div_zero_d   = div_zero_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               op_d    = op[1:0];
               dest_d  = destReg;
               hi_d    = '0;
               // Multiply walks the multiplier through lo; divide shifts the dividend out of lo.
               lo_d    = op[1] ? mag_a : mag_b;
               b_d     = op[1] ? mag_b : mag_a;
            end
         end
         ST_RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d      = ST_DONE;
               result_d     = final_res;
               result_reg_d = dest_q;
               div_zero_d   = op_q[1] & b_zero;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         dest_q       <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         b_q          <= '0;
         result_q     <= '0;
         result_reg_q <= '0;
         div_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         dest_q       <= dest_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         b_q          <= b_d;
         result_q     <= result_d;
         result_reg_q <= result_reg_d;
         div_zero_q   <= div_zero_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign writeEnable = done;
   assign result      = result_q;
   assign resultReg   = result_reg_q;
   assign divByZero   = div_zero_q;

endmodule
